// File: rtl/edge_detect_multi.sv
// Multi-channel level-to-pulse converter: optional synchroniser, persistence
// filter, per-channel edge-mode select, pulse stretcher and sticky event flag.

module edge_detect_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 0,
    parameter int PULSE_LEN   = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       level_i,
    input  logic [1:0] mode_i,
    input  logic       flag_clr_i,
    output logic       pulse_o,
    output logic       flag_o
);
    localparam int CW = (FILT_CYCLES > 0) ? $clog2(FILT_CYCLES + 1) : 1;
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam logic [CW-1:0] FILT_MAX     = CW'(FILT_CYCLES);
    localparam logic [PW-1:0] STRETCH_LOAD = PW'(PULSE_LEN);

    logic s;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= level_i;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign s = level_i;
        end
    endgenerate

    logic          f_q, f_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] stretch_q, stretch_d;
    logic          pulse_q, flag_q, flag_d;
    logic          accept, evt;

    // The filter runs irrespective of mode so that enabling a channel never
    // sees a stale level difference as an edge.
    always_comb begin
        f_d    = f_q;
        cnt_d  = '0;
        accept = 1'b0;
        if (s != f_q) begin
            if (cnt_q == FILT_MAX) begin
                accept = 1'b1;
                f_d    = s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // mode_i[0] enables rising events, mode_i[1] falling events.
    assign evt = accept & (s ? mode_i[0] : mode_i[1]);

    always_comb begin
        stretch_d = '0;
        if (evt)                 stretch_d = STRETCH_LOAD;
        else if (stretch_q != '0) stretch_d = stretch_q - PW'(1);
    end

    assign flag_d = evt | (flag_q & ~flag_clr_i);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f_q       <= 1'b0;
            cnt_q     <= '0;
            stretch_q <= '0;
            pulse_q   <= 1'b0;
            flag_q    <= 1'b0;
        end else begin
            f_q       <= f_d;
            cnt_q     <= cnt_d;
            stretch_q <= stretch_d;
            pulse_q   <= (stretch_d != '0);
            flag_q    <= flag_d;
        end
    end

    assign pulse_o = pulse_q;
    assign flag_o  = flag_q;
endmodule

module edge_detect_multi #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 0,
    parameter int PULSE_LEN   = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_CH-1:0]   level,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   flag_clr,
    output logic [N_CH-1:0]   pulse,
    output logic [N_CH-1:0]   flag,
    output logic              any_pulse
);
    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            edge_detect_ch #(
                .SYNC_STAGES(SYNC_STAGES),
                .FILT_CYCLES(FILT_CYCLES),
                .PULSE_LEN  (PULSE_LEN)
            ) u_ch (
                .clk       (clk),
                .rstn      (rstn),
                .level_i   (level[g]),
                .mode_i    (mode[2*g+1:2*g]),
                .flag_clr_i(flag_clr[g]),
                .pulse_o   (pulse[g]),
                .flag_o    (flag[g])
            );
        end
    endgenerate

    assign any_pulse = |pulse;
endmodule

// File: tb/tb_edge_detect_multi.sv
// Scoreboard bench for edge_detect_multi: driver pushes model predictions per
// clock edge, monitor pops and compares them after each edge.

module tb_edge_detect_multi;
    localparam int N_CH        = 4;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_CYCLES = 2;
    localparam int PULSE_LEN   = 4;
    localparam int HW          = SYNC_STAGES + FILT_CYCLES + 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [N_CH-1:0]   level = '0;
    logic [2*N_CH-1:0] mode = '0;
    logic [N_CH-1:0]   flag_clr = '0;
    logic [N_CH-1:0]   pulse, flag;
    logic              any_pulse;

    edge_detect_multi #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYCLES(FILT_CYCLES), .PULSE_LEN(PULSE_LEN)
    ) dut (
        .clk(clk), .rstn(rstn), .level(level), .mode(mode),
        .flag_clr(flag_clr), .pulse(pulse), .flag(flag), .any_pulse(any_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_CH-1:0] p;
        logic [N_CH-1:0] f;
    } exp_t;

    exp_t sbq[$];
    int n_checks = 0;
    int n_err    = 0;
    int edge_n   = 0;

    // Reference model: level history per channel, accepted level, event time.
    logic [HW-1:0]   lh [N_CH];
    logic [N_CH-1:0] fm;
    logic [N_CH-1:0] mflag;
    int              last_ev [N_CH];

    task automatic chk(input string name, input logic [N_CH-1:0] got, input logic [N_CH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s edge=%0d got=%b exp=%b", name, edge_n, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < N_CH; c++) begin
            lh[c]      = '0;
            last_ev[c] = -1000;
        end
        fm    = '0;
        mflag = '0;
    endfunction

    // A new level is accepted once the last FILT_CYCLES+1 synchronised samples
    // all differ from the accepted level; sample delay equals SYNC_STAGES.
    task automatic step(input logic [N_CH-1:0] lv, input logic [2*N_CH-1:0] md,
                        input logic [N_CH-1:0] clr);
        exp_t e;
        logic acc, ev;
        @(negedge clk);
        rstn = 1'b1; level = lv; mode = md; flag_clr = clr;
        edge_n++;
        for (int c = 0; c < N_CH; c++) begin
            lh[c] = (lh[c] << 1) | HW'(lv[c]);
            acc = 1'b1;
            for (int j = SYNC_STAGES; j <= SYNC_STAGES + FILT_CYCLES; j++)
                if (lh[c][j] == fm[c]) acc = 1'b0;
            if (acc) fm[c] = ~fm[c];
            ev = acc && (fm[c] ? md[2*c] : md[2*c+1]);
            if (ev) last_ev[c] = edge_n;
            mflag[c] = ev ? 1'b1 : (clr[c] ? 1'b0 : mflag[c]);
            e.p[c] = (edge_n - last_ev[c]) < PULSE_LEN;
        end
        e.f = mflag;
        sbq.push_back(e);
    endtask

    task automatic run(input logic [N_CH-1:0] lv, input logic [2*N_CH-1:0] md,
                       input logic [N_CH-1:0] clr, input int n);
        for (int i = 0; i < n; i++) step(lv, md, clr);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_pulse", pulse, '0);
        chk("rst_flag", flag, '0);
        chk("rst_any", N_CH'(any_pulse), '0);
        model_reset();
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin : mon
        exp_t e;
        #2;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("pulse", pulse, e.p);
            chk("flag", flag, e.f);
            chk("any_pulse", N_CH'(any_pulse), N_CH'(|e.p));
        end
    end

    initial begin
        logic [N_CH-1:0]   lv;
        logic [2*N_CH-1:0] md;
        logic [N_CH-1:0]   clr;

        model_reset();
        #1;
        chk("init_pulse", pulse, '0);
        chk("init_flag", flag, '0);
        chk("init_any", N_CH'(any_pulse), '0);
        repeat (3) @(negedge clk);

        // Rising-only: rise pulses once, fall is ignored, flag sticks until cleared.
        md = 8'b01_01_01_01;
        run(4'b0000, md, 4'b0000, 3);
        run(4'b0001, md, 4'b0000, 10);
        run(4'b0000, md, 4'b0000, 10);
        run(4'b0000, md, 4'b0001, 1);
        run(4'b0000, md, 4'b0000, 3);

        // Both edges: short glitch dropped, accepted rise then fall retrigger.
        md = 8'b11_11_11_11;
        run(4'b0001, md, 4'b0000, FILT_CYCLES);
        run(4'b0000, md, 4'b0000, 8);
        run(4'b0001, md, 4'b0000, FILT_CYCLES + 1);
        run(4'b0000, md, 4'b0000, 12);

        // Clear held across the accepting edge, then a lone clear.
        md = 8'b00_01_00_00;
        run(4'b0100, md, 4'b0100, 8);
        run(4'b0100, md, 4'b0000, 3);
        run(4'b0000, md, 4'b0000, 8);
        run(4'b0100, md, 4'b0000, 8);
        run(4'b0100, md, 4'b0100, 1);
        run(4'b0100, md, 4'b0000, 2);

        // Mode off with toggling level, then enable while steady high.
        for (int i = 0; i < 6; i++) run((i % 2) ? 4'b1000 : 4'b0000, 8'h00, 4'b0000, 4);
        run(4'b1000, 8'h00, 4'b0000, 6);
        run(4'b1000, 8'b01_00_00_00, 4'b0000, 8);

        // Reset mid-stretch, level held high through release.
        md = 8'b01_01_01_01;
        run(4'b0000, md, 4'b0000, 8);
        run(4'b0001, md, 4'b0000, SYNC_STAGES + FILT_CYCLES + 2);
        do_reset(2);
        run(4'b0001, md, 4'b0000, 12);

        // Simultaneous events across channels: ch0/ch3 rise, ch1 falls.
        md = 8'b01_00_10_01;
        run(4'b0000, md, 4'b0000, 8);
        run(4'b0010, md, 4'b0000, 8);
        run(4'b1001, md, 4'b0000, 10);

        // Randomised traffic with occasional mode changes and one reset.
        lv = '0;
        md = 8'hE4;
        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(3) == 0) lv[c] = ~lv[c];
                clr[c] = ($urandom_range(7) == 0);
            end
            if (i % 40 == 39) md = 2*N_CH'($urandom);
            if (i == 250) do_reset(3);
            step(lv, md, clr);
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain got=%0d exp=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
Multi-channel, parametrised successor to the single-bit rising-edge pulser. Each channel has four stages:
- optional synchroniser for asynchronous inputs
- glitch/debounce filter
- per-channel edge-mode selection (rise/fall/both/off)
- pulse stretching, plus a sticky event flag with clear

Used at the event-input and control boundary to turn level strobes into single-cycle or stretched pulses.

Parameters:
N_CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel ahead of the filter (0 = input used directly)
FILT_CYCLES, 0, extra consecutive cycles a new level must persist before acceptance (0 = no filtering)
PULSE_LEN, 1, output pulse width in cycles per event (>=1)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
level  in  N_CH  raw level inputs, one bit per channel
mode  in  2*N_CH  per-channel mode, bits [2i+1:2i] belong to channel i: 00 off, 01 rising, 10 falling, 11 both
flag_clr  in  N_CH  per-channel sticky-flag clear, single-cycle strobe
pulse  out  N_CH  per-channel event pulse, registered
flag  out  N_CH  per-channel sticky event flag, registered
any_pulse  out  1  OR of all pulse bits (combinational from registers)

Behaviour:
- Reset: rstn low asynchronously clears all sync flops, filtered state f, filter counters, stretch counters, pulse and flag. any_pulse reads 0 during reset.
- Sync stage: s = level delayed by SYNC_STAGES flops; s = level when SYNC_STAGES=0.
- Filter, per channel, with counter cnt of width clog2(FILT_CYCLES+1), minimum 1:
  - if s == f: cnt <= 0.
  - if s != f and cnt < FILT_CYCLES: cnt <= cnt+1, f unchanged.
  - if s != f and cnt == FILT_CYCLES: accept. f <= s, cnt <= 0.
  - Effect: a new level must be sampled on FILT_CYCLES+1 consecutive edges; shorter glitches are dropped silently.
- Event: raised at the accepting edge when the mode matches the direction. Rise = accept with s=1; fall = accept with s=0. mode 00 never raises an event.
- The filter tracks continuously regardless of mode. Enabling a channel therefore never produces a spurious edge from stale state.
- Latency: level change at the input of an edge-k sample -> pulse high after edge k+SYNC_STAGES+FILT_CYCLES. Total = 1+SYNC_STAGES+FILT_CYCLES cycles. With 0/0/1 this is identical to the legacy 1-cycle rise detector.
- Stretch: an event loads the stretch counter with PULSE_LEN, and pulse is high while the counter is non-zero. pulse is high exactly PULSE_LEN cycles starting the cycle after the event edge.
  - Retrigger while pulse is active reloads the counter, so pulse stays continuously high; there is no gap and no extra edge.
- Flag: set on event, cleared by flag_clr.
  - Event and flag_clr at the same edge: set wins, flag = 1.
  - flag_clr with no event: flag = 0 next cycle.
- Power-up: f resets to 0. A channel held high through reset release produces one rising event (if its mode allows) after full latency. A channel held low produces nothing.
- Reset mid-pulse: pulse drops immediately (async) and the counter is cleared. No resumption after reset release.
- Mode change takes effect from the next accepting edge. An in-flight stretched pulse completes regardless.
- Channels are fully independent, with no cross-channel arbitration. Simultaneous events on multiple channels all pulse in the same cycle.

Test Plan:
- N_CH=1, SYNC_STAGES=0, FILT_CYCLES=0, PULSE_LEN=1, mode=01: level 0->1 sampled at edge 10 -> pulse=1 only in cycle after edge 10; 1->0 -> no pulse; flag=1 until flag_clr.
- SYNC_STAGES=2, FILT_CYCLES=3, mode=11: 3-cycle high glitch -> no pulse. 4-cycle high -> one pulse 6 cycles after rise. Later low for 4 cycles -> a second pulse (falling edge).
- PULSE_LEN=4, mode=01: two accepted rises 2 cycles apart -> pulse continuously high 6 cycles, any_pulse matches, flag=1.
- Event coinciding with flag_clr -> flag stays 1. flag_clr alone next cycle -> flag=0. mode=00 with toggling level -> pulse and flag stay 0. Switching to 01 while level is steady high -> no pulse.
- rstn asserted mid-stretch (PULSE_LEN=8, cycle 3) -> pulse and flag 0 immediately. Level held high through release -> exactly one rising pulse after 1+SYNC_STAGES+FILT_CYCLES cycles.
- N_CH=4, rise on ch0 and ch3 on the same edge, ch1 mode=10 falling -> pulse=4'b1011 in the same cycle.
